// File: rtl/mdu_pkg.sv
// Shared types and sizes for the multiply/divide unit.
package mdu_pkg;
  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mduOpT;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mduStateT;

  // Magnitude of an operand; unsigned ops pass the raw value through.
  function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v, input logic isSigned);
    return (isSigned && v[WIDTH-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// The divide path exists only when MDU_DIV_EN is defined.
module mdu_step
  import mdu_pkg::*;
(
  input  logic             isDiv,
  input  logic [WIDTH-1:0] accHi,
  input  logic [WIDTH-1:0] accLo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nextHi,
  output logic [WIDTH-1:0] nextLo
);
  logic [WIDTH:0] sum;
`ifdef MDU_DIV_EN
  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] diff;
`else
  logic unusedIsDiv;
  assign unusedIsDiv = isDiv;
`endif

  // Multiply: add multiplicand when the low multiplier bit is set, then shift the pair right.
  // Divide: shift the remainder/quotient pair left and subtract the divisor if it fits.
  always_comb begin
    sum    = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
    nextHi = sum[WIDTH:1];
    nextLo = {sum[0], accLo[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    remShift = {accHi, accLo[WIDTH-1]};
    // Result fits WIDTH bits whenever the subtraction is taken.
    diff     = remShift[WIDTH-1:0] - operand;
    if (isDiv) begin
      if (remShift >= {1'b0, operand}) begin
        nextHi = diff;
        nextLo = {accLo[WIDTH-2:0], 1'b1};
      end else begin
        nextHi = remShift[WIDTH-1:0];
        nextLo = {accLo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Define MDU_DIV_EN to build the DIV/DIVU datapath; otherwise divide
// requests complete immediately with no effect.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  mduStateT state, stateNext;
  mduOpT    opReg;
  logic [WIDTH-1:0] accHi, accLo, operand, stepHi, stepLo;
  logic [CNT_W-1:0] cnt;
  logic negA, negB, dzFlag;
  logic signedIn, divIn, skipRun;
  logic [2*WIDTH-1:0] prod, prodFix;
`ifdef MDU_DIV_EN
  logic bZero;
  logic [WIDTH-1:0] quoFix, remFix;
`endif

  assign signedIn = ~op[0];
  assign divIn    = op[1];
`ifdef MDU_DIV_EN
  assign bZero    = (b_in == '0);
  assign skipRun  = divIn & bZero;
`else
  assign skipRun  = divIn;
`endif

  mdu_step uStep (
    .isDiv  (opReg[1]),
    .accHi  (accHi),
    .accLo  (accLo),
    .operand(operand),
    .nextHi (stepHi),
    .nextLo (stepLo)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= stateNext;
  end

  // Next-state: 32 RUN cycles, one FIX cycle, one DONE pulse; start only seen in IDLE.
  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:  if (start) stateNext = skipRun ? S_DONE : S_RUN;
      S_RUN:   if (cnt == CNT_W'(ITER-1)) stateNext = S_FIX;
      S_FIX:   stateNext = S_DONE;
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // Sign correction of the magnitude result before it lands in HI/LO.
  always_comb begin
    prod    = {accHi, accLo};
    prodFix = (opReg == OP_MULT && (negA ^ negB)) ? -prod : prod;
`ifdef MDU_DIV_EN
    quoFix  = (opReg == OP_DIV && (negA ^ negB)) ? -accLo : accLo;
    remFix  = (opReg == OP_DIV && negA) ? -accHi : accHi;
`endif
  end

  // Operand capture, iteration and result write-back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opReg   <= OP_MULT;
      accHi   <= '0;
      accLo   <= '0;
      operand <= '0;
      cnt     <= '0;
      negA    <= 1'b0;
      negB    <= 1'b0;
      dzFlag  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          opReg   <= mduOpT'(op);
          accHi   <= '0;
          accLo   <= absVal(a_in, signedIn);
          operand <= absVal(b_in, signedIn);
          cnt     <= '0;
          negA    <= signedIn & a_in[WIDTH-1];
          negB    <= signedIn & b_in[WIDTH-1];
`ifdef MDU_DIV_EN
          dzFlag  <= divIn & bZero;
`else
          dzFlag  <= 1'b0;
`endif
        end
        S_RUN: begin
          accHi <= stepHi;
          accLo <= stepLo;
          cnt   <= cnt + 1'b1;
        end
        S_FIX: begin
`ifdef MDU_DIV_EN
          if (opReg[1]) begin
            hi <= remFix;
            lo <= quoFix;
          end else begin
            hi <= prodFix[2*WIDTH-1:WIDTH];
            lo <= prodFix[WIDTH-1:0];
          end
`else
          hi <= prodFix[2*WIDTH-1:WIDTH];
          lo <= prodFix[WIDTH-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state == S_RUN) || (state == S_FIX);
  assign done     = (state == S_DONE);
  assign div_zero = done & dzFlag;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit; divide expectations follow MDU_DIV_EN.
module tb_mul_div_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] aIn   = '0;
  logic [31:0] bIn   = '0;
  logic        busy, done, divZero;
  logic [31:0] hi, lo;
  int checks   = 0;
  int failures = 0;

  mul_div_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .a_in(aIn), .b_in(bIn), .busy(busy), .done(done),
    .div_zero(divZero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  // Issue one op, wait (bounded) for done, return latency and results.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] h, output logic [31:0] l,
                        output logic dz);
    @(negedge clock);
    op = o; aIn = a; bIn = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0; aIn = $urandom; bIn = $urandom; op = ~o;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    h = hi; l = lo; dz = divZero;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      failures++; $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", hi, lo);
    end
    checks++;
    if ({busy, done, divZero} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got busy/done/dz=%b expected 000", {busy, done, divZero});
    end
    reset = 1'b0;
  endtask

  // Start in the same cycle reset drops; check busy/done timing and HI/LO hold.
  task automatic test_multu_max;
    logic expBusy, expDone;
    op = 2'b01; aIn = '1; bIn = '1; start = 1'b1;
    @(negedge clock);
    start = 1'b0; aIn = 32'h1234; bIn = 32'h0; op = 2'b11;
    for (int n = 1; n <= 35; n++) begin
      expBusy = (n <= 33);
      expDone = (n == 34);
      checks++;
      if (busy !== expBusy || done !== expDone) begin
        failures++; $display("FAIL multu_timing n=%0d: got busy=%b done=%b expected busy=%b done=%b",
                             n, busy, done, expBusy, expDone);
      end
      if (n <= 33) begin
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
          failures++; $display("FAIL multu_hold n=%0d: got hi=%h lo=%h expected 0/0", n, hi, lo);
        end
      end
      if (n == 34) begin
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001 || divZero !== 1'b0) begin
          failures++; $display("FAIL multu_max: got hi=%h lo=%h dz=%b expected fffffffe/00000001/0", hi, lo, divZero);
        end
      end
      @(negedge clock);
    end
  endtask

  task automatic test_mult;
    logic [1:0]  tOp [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    logic [31:0] tA  [6] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h00000007, 32'h12345678, 32'd6};
    logic [31:0] tB  [6] = '{32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'h00000010, 32'd7};
    logic [31:0] eH  [6] = '{32'hFFFFFFFF, 32'h40000000, 32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h0};
    logic [31:0] eL  [6] = '{32'hFFFFFFF1, 32'h0, 32'h1, 32'hFFFFFFD6, 32'h23456780, 32'd42};
    int lat; logic [31:0] h, l; logic dz;
    for (int i = 0; i < 6; i++) begin
      run_op(tOp[i], tA[i], tB[i], lat, h, l, dz);
      checks++;
      if (lat !== 34 || h !== eH[i] || l !== eL[i] || dz !== 1'b0) begin
        failures++; $display("FAIL mult[%0d]: got lat=%0d hi=%h lo=%h dz=%b expected 34/%h/%h/0",
                             i, lat, h, l, dz, eH[i], eL[i]);
      end
    end
  endtask

  task automatic test_divide;
    logic [1:0]  tOp [5] = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
    logic [31:0] tA  [5] = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd7, 32'hFFFFFFFF};
    logic [31:0] tB  [5] = '{32'd2, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd16};
`ifdef MDU_DIV_EN
    logic [31:0] eH  [5] = '{32'hFFFFFFFF, 32'd2, 32'h0, 32'd1, 32'hF};
    logic [31:0] eL  [5] = '{32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFD, 32'h0FFFFFFF};
    int eLat = 34;
`else
    logic [31:0] eH  [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] eL  [5] = '{32'd42, 32'd42, 32'd42, 32'd42, 32'd42};
    int eLat = 1;
`endif
    int lat; logic [31:0] h, l; logic dz;
    for (int i = 0; i < 5; i++) begin
      run_op(tOp[i], tA[i], tB[i], lat, h, l, dz);
      checks++;
      if (lat !== eLat || h !== eH[i] || l !== eL[i] || dz !== 1'b0) begin
        failures++; $display("FAIL div[%0d]: got lat=%0d hi=%h lo=%h dz=%b expected %0d/%h/%h/0",
                             i, lat, h, l, dz, eLat, eH[i], eL[i]);
      end
    end
  endtask

  task automatic test_div_zero;
`ifdef MDU_DIV_EN
    logic [31:0] eH = 32'hF, eL = 32'h0FFFFFFF; logic eDz = 1'b1;
`else
    logic [31:0] eH = 32'h0, eL = 32'd42;       logic eDz = 1'b0;
`endif
    int lat; logic [31:0] h, l; logic dz;
    run_op(2'b11, 32'd100, 32'd0, lat, h, l, dz);
    checks++;
    if (lat !== 1 || h !== eH || l !== eL || dz !== eDz) begin
      failures++; $display("FAIL divu_zero: got lat=%0d hi=%h lo=%h dz=%b expected 1/%h/%h/%b", lat, h, l, dz, eH, eL, eDz);
    end
    checks++;
    if (done !== 1'b0 || divZero !== 1'b0) begin
      failures++; $display("FAIL dz_after_done: got done=%b dz=%b expected 0/0", done, divZero);
    end
    run_op(2'b10, 32'd5, 32'd0, lat, h, l, dz);
    checks++;
    if (lat !== 1 || h !== eH || l !== eL || dz !== eDz) begin
      failures++; $display("FAIL div_zero: got lat=%0d hi=%h lo=%h dz=%b expected 1/%h/%h/%b", lat, h, l, dz, eH, eL, eDz);
    end
  endtask

  // A start pulse mid-RUN must be dropped, not queued.
  task automatic test_start_ignored;
    int doneCnt = 0; logic [31:0] resLo = '0;
    @(negedge clock);
    op = 2'b01; aIn = 32'd6; bIn = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      if (done) begin doneCnt++; resLo = lo; end
      start = (n == 5);
      if (n == 5) begin op = 2'b01; aIn = 32'd3; bIn = 32'd3; end
      @(negedge clock);
    end
    start = 1'b0;
    checks++;
    if (doneCnt !== 1) begin
      failures++; $display("FAIL start_ignored_count: got %0d done pulses expected 1", doneCnt);
    end
    checks++;
    if (resLo !== 32'd42 || busy !== 1'b0) begin
      failures++; $display("FAIL start_ignored_result: got lo=%0d busy=%b expected 42/0", resLo, busy);
    end
  endtask

  // Reset mid-RUN clears HI/LO, produces no done, and the next op works.
  task automatic test_reset_abort;
    int doneCnt = 0; int lat; logic [31:0] h, l; logic dz;
    @(negedge clock);
    op = 2'b01; aIn = 32'hFFFFFFFF; bIn = 32'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_abort: got hi=%h lo=%h busy=%b done=%b expected 0/0/0/0", hi, lo, busy, done);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done) doneCnt++;
      @(negedge clock);
    end
    checks++;
    if (doneCnt !== 0) begin
      failures++; $display("FAIL reset_no_done: got %0d done pulses expected 0", doneCnt);
    end
    run_op(2'b01, 32'd6, 32'd7, lat, h, l, dz);
    checks++;
    if (lat !== 34 || h !== 32'h0 || l !== 32'd42) begin
      failures++; $display("FAIL post_reset_multu: got lat=%0d hi=%h lo=%0d expected 34/0/42", lat, h, l);
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult();
    test_divide();
    test_div_zero();
    test_start_ignored();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
